// File: rtl/button_event_arbiter_pkg.sv
// rtl/button_event_arbiter_pkg.sv - shared constants, FSM states and helpers for the button event arbiter
package button_event_arbiter_pkg;

   // Sample tick divider: short for simulation, 1 ms at 100 MHz for the board build
   localparam int SIM_TICK_DIV     = 19;
   localparam int BOARD_TICK_DIV   = 99_999;
   localparam int DEF_STABLE_TICKS = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } arb_state_t;

   // Number of bits needed to index 'value' items (0 for a single item)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_event_arbiter_btn_filter.sv
// rtl/button_event_arbiter_btn_filter.sv - per-button synchroniser, tick-sampled debounce filter and press pulse
module button_event_arbiter_btn_filter
   import button_event_arbiter_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_btn_in,
   output logic o_level,
   output logic o_press
);

   localparam int             CNW      = clog2(STABLE_TICKS) + 1;
   localparam logic [CNW-1:0] CNT_LAST = CNW'(STABLE_TICKS - 1);

   logic           r_sync0;
   logic           r_sync1;
   logic           r_level;
   logic           r_level_q;
   logic [CNW-1:0] r_cnt;

   // Synchronise every clk; on a tick, flip the level only after enough consecutive disagreeing samples
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync0   <= 1'b0;
         r_sync1   <= 1'b0;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync0   <= i_btn_in;
         r_sync1   <= r_sync0;
         r_level_q <= r_level;
         if (i_tick) begin
            if (r_sync1 == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_level <= r_sync1;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNW'(1);
            end
         end
      end
   end

   assign o_level = r_level;
   // A press is the cycle after the debounced level rises
   assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - shared-tick button debouncer with round-robin event serialiser
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter  int NUM_BTN      = 4,
   parameter  int TICK_DIV     = SIM_TICK_DIV,
   parameter  int STABLE_TICKS = DEF_STABLE_TICKS,
   localparam int IDW          = clog2(NUM_BTN)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_BTN-1:0] i_btn_in,
   output logic [NUM_BTN-1:0] o_btn_level,
   output logic               o_evt_valid,
   input  logic               i_evt_ready,
   output logic [IDW-1:0]     o_evt_id,
   output logic [NUM_BTN-1:0] o_ovr,
   input  logic               i_ovr_clr
);

   localparam int            CW        = clog2(TICK_DIV + 1);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV);

   logic [CW-1:0]      r_tick_cnt;
   logic               w_tick;
   logic [NUM_BTN-1:0] w_level;
   logic [NUM_BTN-1:0] w_press;
   logic [NUM_BTN-1:0] r_pending;
   logic [NUM_BTN-1:0] r_ovr;
   logic [NUM_BTN-1:0] w_clr;
   logic [NUM_BTN-1:0] w_ovr_set;
   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [IDW-1:0]     r_evt_id;
   logic [IDW-1:0]     w_evt_id_nxt;
   logic [IDW-1:0]     r_ptr;
   logic [IDW-1:0]     w_ptr_nxt;
   logic               w_found;
   logic [IDW-1:0]     w_pick;

   assign w_tick = (r_tick_cnt == TICK_LAST);

   // Shared sample-tick counter, wraps to 0 on the tick cycle
   always_ff @(posedge i_clk) begin
      if (i_rst || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + CW'(1);
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_filter
      button_event_arbiter_btn_filter #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_filter (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_tick   (w_tick),
         .i_btn_in (i_btn_in[g]),
         .o_level  (w_level[g]),
         .o_press  (w_press[g])
      );
   end

   // Round-robin search: first pending button at or above the pointer, wrapping around
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         int idx;
         idx = (int'(r_ptr) + k) % NUM_BTN;
         if (!w_found && r_pending[idx]) begin
            w_found = 1'b1;
            w_pick  = IDW'(idx);
         end
      end
   end

   // Arbiter next state: latch a winner in IDLE, hold the offer until the handshake
   always_comb begin
      w_state_nxt  = r_state;
      w_evt_id_nxt = r_evt_id;
      w_ptr_nxt    = r_ptr;
      w_clr        = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt  = ST_OFFER;
               w_evt_id_nxt = w_pick;
            end
         end
         ST_OFFER: begin
            if (i_evt_ready) begin
               w_state_nxt = ST_IDLE;
               w_clr       = NUM_BTN'(1) << r_evt_id;
               w_ptr_nxt   = (r_evt_id == IDW'(NUM_BTN - 1)) ? '0 : r_evt_id + IDW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Arbiter state, offered id and round-robin pointer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_evt_id <= '0;
         r_ptr    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_evt_id <= w_evt_id_nxt;
         r_ptr    <= w_ptr_nxt;
      end
   end

   // A fresh press beats the handshake clear; overrun only when the old press is still waiting
   assign w_ovr_set = w_press & r_pending & ~w_clr;

   // Pending events and sticky overrun flags (set wins over ovr_clr)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pending <= '0;
         r_ovr     <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_press;
         r_ovr     <= i_ovr_clr ? w_ovr_set : (r_ovr | w_ovr_set);
      end
   end

   assign o_btn_level = w_level;
   assign o_evt_valid = (r_state == ST_OFFER);
   assign o_evt_id    = r_evt_id;
   assign o_ovr       = r_ovr;

endmodule
